// File: rtl/dcache_ctrl_if.sv
// CPU-side and data_mem-side signal bundle for dcache_ctrl.
// The slave modport is the cache controller's view; master is the surrounding CPU/memory view.
interface dcache_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_wd;
    logic [DATA_WIDTH-1:0]    cpu_rd;
    logic                     cpu_stall;
    logic                     flush;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wd;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd, flush, mem_ready, mem_rd,
        output cpu_rd, cpu_stall, mem_req, mem_we, mem_addr, mem_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd, flush, mem_ready, mem_rd,
        input  cpu_rd, cpu_stall, mem_req, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate data cache controller.
// Optional hit/miss/write-through counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DCACHE_STATS_EN
    dcache_ctrl_if.slave          bus,
    output logic [DATA_WIDTH-1:0] hit_count,
    output logic [DATA_WIDTH-1:0] miss_count,
    output logic [DATA_WIDTH-1:0] wt_count
`else
    dcache_ctrl_if.slave          bus
`endif
);
    localparam int NLINES = 1 << INDEX_BITS;
    localparam int TAG_W  = ADDRESS_WIDTH - INDEX_BITS - 2;
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(3);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]               state;
    logic [NLINES-1:0]        valid;
    logic [TAG_W-1:0]         tag_arr  [NLINES];
    logic [DATA_WIDTH-1:0]    data_arr [NLINES];

    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wd_q;
    logic [DATA_WIDTH-1:0]    rd_q;

    logic [INDEX_BITS-1:0]    index;
    logic [TAG_W-1:0]         tag;
    logic [ADDRESS_WIDTH-1:0] aligned_addr;
    logic                     hit;
    logic                     idle_go;
    logic                     idle_ld_hit;
    logic                     idle_ld_miss;
    logic                     refill_done;
    logic                     write_done;

    assign index        = bus.cpu_addr[INDEX_BITS+1:2];
    assign tag          = bus.cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign aligned_addr = bus.cpu_addr & ~OFFSET_MASK;
    assign hit          = valid[index] && (tag_arr[index] == tag);

    // Flush wins over a request in the same cycle; the request is re-presented next cycle.
    assign idle_go      = (state == S_IDLE) && bus.cpu_req && !bus.flush;
    assign idle_ld_hit  = idle_go && !bus.cpu_we && hit;
    assign idle_ld_miss = idle_go && !bus.cpu_we && !hit;
    assign refill_done  = (state == S_REFILL) && bus.mem_ready;
    assign write_done   = (state == S_WRITE) && bus.mem_ready;

    always_comb begin
        bus.cpu_stall = 1'b0;
        unique case (state)
            S_IDLE:   bus.cpu_stall = bus.cpu_req && (bus.flush || bus.cpu_we || !hit);
            S_REFILL: bus.cpu_stall = 1'b1;
            S_WRITE:  bus.cpu_stall = 1'b1;
            default:  bus.cpu_stall = 1'b0;
        endcase
    end

    assign bus.cpu_rd   = idle_ld_hit ? data_arr[index] : rd_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            valid      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            rd_q       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.cpu_req && bus.cpu_we) begin
                        state      <= S_WRITE;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= aligned_addr;
                        mem_wd_q   <= bus.cpu_wd;
                    end else if (idle_ld_miss) begin
                        state      <= S_REFILL;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= aligned_addr;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ready) begin
                        valid[index] <= 1'b1;
                        rd_q         <= bus.mem_rd;
                        mem_req_q    <= 1'b0;
                        state        <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && refill_done) begin
            data_arr[index] <= bus.mem_rd;
            tag_arr[index]  <= tag;
        end else if (!rst && write_done && hit) begin
            data_arr[index] <= bus.cpu_wd;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wt_count   <= '0;
        end else begin
            if (idle_ld_hit)  hit_count  <= hit_count + 1'b1;
            if (idle_ld_miss) miss_count <= miss_count + 1'b1;
            if (write_done)   wt_count   <= wt_count + 1'b1;
        end
    end
`endif
endmodule
